pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor built from generic GROUP-bit carry-lookahead groups. Operand width is split into STAGES slices, and the slice carry is registered between stages, so Fmax no longer scales with WIDTH. A valid/ready handshake on both sides provides backpressure. The block also adds subtract mode and carry/overflow/zero flags. It sits in the datapath as the shared ALU add/sub unit.

---
 rtl/pipelined_addsub_pkg.sv | 19 +
 rtl/pipelined_addsub_if.sv | 32 +++
 rtl/pipelined_addsub_cla_group.sv | 50 +++++
 rtl/pipelined_addsub.sv | 151 +++++++++++++++
 tb/tb_pipelined_addsub.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined add/sub ALU: default geometry and the result bundle.
// No logic; pure types and constants.
// Not applicable (no handshake here).
package pipelined_addsub_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_GROUP  = 4;
   localparam int DEF_STAGES = 2;
   localparam int SLICE      = DEF_WIDTH / DEF_STAGES;

   // Result bundle as seen by ALU consumers; field order matches {sum, cout, ovf, zero}.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] sum;
      logic                 cout;
      logic                 ovf;
      logic                 zero;
   } res_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined add/sub unit.
// Wires only; no latency.
// Valid/ready on both the operand side and the result side.
interface pipelined_addsub_if
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );

endinterface

// File: rtl/pipelined_addsub_cla_group.sv
// GROUP-bit carry-lookahead adder cell: flat generate/propagate carries, no internal ripple.
// Purely combinational.
// No handshake.
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP:0]   c;
   logic             term;
   logic             acc;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is an explicit sum of products of g/p terms, so depth stays flat across the group.
   always_comb begin
      c    = '0;
      term = 1'b0;
      acc  = 1'b0;
      c[0] = cin;
      for (int i = 0; i < GROUP; i++) begin
         acc = cin;
         for (int k = 0; k <= i; k++) begin
            acc = acc & p[k];
         end
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & p[k];
            end
            acc = acc | term;
         end
         c[i+1] = acc;
      end
   end

   assign sum   = p ^ c[GROUP-1:0];
   assign cout  = c[GROUP];
   assign c_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub: one WIDTH/STAGES slice per stage, slice carry registered.
// Latency STAGES cycles, throughput one beat per cycle.
// Per-stage ready = !valid || downstream ready; in_ready is combinational from out_ready.
module pipelined_addsub
   import pipelined_addsub_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int GROUP  = DEF_GROUP,
   parameter int STAGES = DEF_STAGES
) (
   input logic               clk,
   input logic               rst,
   pipelined_addsub_if.slave bus
);

   localparam int SW   = (STAGES > 0) ? WIDTH / STAGES : WIDTH;
   localparam int NGRP = (GROUP > 0) ? SW / GROUP : 1;
   localparam bit BAD  = (STAGES < 1 || GROUP < 1) ? 1'b1 : ((WIDTH % (STAGES * GROUP)) != 0);

   if (BAD) begin : g_bad_params
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES*GROUP with STAGES>=1, GROUP>=1");
   end

   // Per-stage pipeline state. a/b/sub are the skewed operands for the slices not yet added;
   // sum_r holds the completed lower slices; c_r is the carry out of the slice just added.
   logic [STAGES-1:0] v;
   logic [WIDTH-1:0]  a_r   [STAGES];
   logic [WIDTH-1:0]  b_r   [STAGES];
   logic [WIDTH-1:0]  sum_r [STAGES];
   logic              sub_r [STAGES];
   logic              c_r   [STAGES];
   logic              cout_r;
   logic              ovf_r;
   logic              zero_r;

   // Stage inputs: from the interface for stage 0, from the previous register otherwise.
   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] c_in;
   logic [STAGES-1:0] sub_in;
   logic [WIDTH-1:0]  a_in  [STAGES];
   logic [WIDTH-1:0]  b_in  [STAGES];
   logic [WIDTH-1:0]  s_in  [STAGES];
   logic [WIDTH-1:0]  s_nxt [STAGES];

   logic [STAGES-1:0][SW-1:0] st_sum;
   logic [STAGES-1:0]         st_cout;
   logic                      grp_cmsb [STAGES][NGRP];
   logic [STAGES:0]           rdy;

   // Backpressure chain: an empty stage always accepts, so bubbles collapse under a stall.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = ~v[k] | rdy[k+1];
      end
   end

   // Route each stage's operands/carry and merge its slice into the running sum.
   always_comb begin
      v_in      = '0;
      c_in      = '0;
      sub_in    = '0;
      v_in[0]   = bus.in_valid;
      c_in[0]   = bus.sub;
      sub_in[0] = bus.sub;
      a_in[0]   = bus.a;
      b_in[0]   = bus.b;
      s_in[0]   = '0;
      for (int k = 1; k < STAGES; k++) begin
         v_in[k]   = v[k-1];
         c_in[k]   = c_r[k-1];
         sub_in[k] = sub_r[k-1];
         a_in[k]   = a_r[k-1];
         b_in[k]   = b_r[k-1];
         s_in[k]   = sum_r[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         s_nxt[k]               = s_in[k];
         s_nxt[k][k*SW +: SW]   = st_sum[k];
      end
   end

   // Slice adders: NGRP lookahead groups per stage, rippling group to group.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      for (genvar j = 0; j < NGRP; j++) begin : g_grp
         localparam int LO = k * SW + j * GROUP;
         logic ci;
         logic co;
         if (j == 0) begin : g_cin_first
            assign ci = c_in[k];
         end else begin : g_cin_chain
            assign ci = g_grp[j-1].co;
         end
         cla_group #(.GROUP(GROUP)) u_cla (
            .a     (a_in[k][LO +: GROUP]),
            .b     (b_in[k][LO +: GROUP] ^ {GROUP{sub_in[k]}}),
            .cin   (ci),
            .sum   (st_sum[k][j*GROUP +: GROUP]),
            .cout  (co),
            .c_msb (grp_cmsb[k][j])
         );
      end
      assign st_cout[k] = g_grp[NGRP-1].co;
   end

   // Advance each stage when it can accept; data registers only load on a valid beat and
   // hold otherwise. Flags are formed from the final stage and registered alongside sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         v      <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_r[k]   <= '0;
            b_r[k]   <= '0;
            sum_r[k] <= '0;
            sub_r[k] <= 1'b0;
            c_r[k]   <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               v[k] <= v_in[k];
               if (v_in[k]) begin
                  a_r[k]   <= a_in[k];
                  b_r[k]   <= b_in[k];
                  sub_r[k] <= sub_in[k];
                  sum_r[k] <= s_nxt[k];
                  c_r[k]   <= st_cout[k];
               end
            end
         end
         if (rdy[STAGES-1] && v_in[STAGES-1]) begin
            cout_r <= st_cout[STAGES-1];
            ovf_r  <= grp_cmsb[STAGES-1][NGRP-1] ^ st_cout[STAGES-1];
            zero_r <= ~|s_nxt[STAGES-1];
         end
      end
   end

   // Neither side transfers while reset is asserted.
   assign bus.in_ready  = rdy[0] & ~rst;
   assign bus.out_valid = v[STAGES-1] & ~rst;
   assign bus.sum       = sum_r[STAGES-1];
   assign bus.cout      = cout_r;
   assign bus.ovf       = ovf_r;
   assign bus.zero      = zero_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, GROUP=4, STAGES=2).
// Expected results are queued at input transfer and compared at output transfer.
// Covers reset, directed corner cases, streaming, backpressure, random stalls, mid-stream reset.
module tb_pipelined_addsub;
   import pipelined_addsub_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipelined_addsub_if #(.WIDTH(W)) bus ();

   pipelined_addsub #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      res_t r;
      int   t;
   } exp_t;

   exp_t sb[$];
   int   n_chk   = 0;
   int   n_err   = 0;
   int   cyc     = 0;
   int   acc_cnt = 0;
   bit   lat_chk = 1'b0;
   bit   hold_chk = 1'b0;
   res_t cur_exp;

   logic [W-1:0] da [8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0007,
                            32'h8000_0000, 32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000};
   logic [W-1:0] db [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0007,
                            32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
   logic         ds [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   // {sum, cout, ovf, zero}
   logic [34:0]  dexp [8] = '{{32'h8000_0000, 3'b010}, {32'h0000_0000, 3'b101},
                              {32'hFFFF_FFFE, 3'b000}, {32'h0000_0000, 3'b101},
                              {32'h7FFF_FFFF, 3'b110}, {32'h0000_0000, 3'b101},
                              {32'h0001_0000, 3'b000}, {32'h0000_FFFF, 3'b100}};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      res_t         r;
      logic [W:0]   full;
      logic [W-1:0] bb;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
      r.zero = (r.sum == '0);
      return r;
   endfunction

   task automatic drive(input logic vld, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      bus.in_valid = vld;
      bus.a        = a;
      bus.b        = b;
      bus.sub      = s;
      cur_exp      = model(a, b, s);
   endtask

   function automatic res_t observed();
      res_t r;
      r = {bus.sum, bus.cout, bus.ovf, bus.zero};
      return r;
   endfunction

   // One clock: look at the settled handshake shortly after the falling edge, book the
   // transfers the next rising edge will perform, then advance to the next falling edge.
   task automatic step();
      exp_t e;
      #1;
      if (hold_chk && bus.out_valid && !bus.out_ready && sb.size() > 0)
         check("hold", observed(), sb[0].r);
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("result", observed(), e.r);
            if (lat_chk) check("latency", cyc - e.t, 2);
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         e.r = cur_exp;
         e.t = cyc;
         sb.push_back(e);
         acc_cnt++;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) step();
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_in_ready"}, bus.in_ready, 1);
      check({tag, "_outputs"}, observed(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      repeat (3) step();
      rst = 1'b0;
      #1;
      check_reset_state("reset");

      // Directed corners, back to back, including carries/borrows across the slice boundary.
      lat_chk = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, da[i], db[i], ds[i]);
         cur_exp = dexp[i];
         step();
      end
      drive(1'b0, '0, '0, 1'b0);
      drain();

      // Streaming: 100 random beats, one per cycle, latency exactly 2.
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
         #1;
         check("stream_in_ready", bus.in_ready, 1);
         step();
      end
      drive(1'b0, '0, '0, 1'b0);
      drain();
      lat_chk = 1'b0;

      // Backpressure: consumer stalled for 5 cycles with a continuous offer.
      bus.out_ready = 1'b0;
      hold_chk      = 1'b1;
      acc_cnt       = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
         step();
      end
      check("bp_accepted", acc_cnt, 2);
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      drive(1'b0, '0, '0, 1'b0);
      bus.out_ready = 1'b1;
      drain();

      // Random offer and random stall.
      for (int i = 0; i < 200; i++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
         step();
      end
      hold_chk      = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      drain();

      // Reset with two beats in flight: nothing may emerge afterwards.
      acc_cnt = 0;
      drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
      step();
      drive(1'b1, 32'h0F0F_0F0F, 32'h0000_0001, 1'b1);
      step();
      check("mid_accepted", acc_cnt, 2);
      drive(1'b0, '0, '0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      #1;
      check_reset_state("mid_reset");
      for (int i = 0; i < 5; i++) begin
         #1;
         check("no_stale", bus.out_valid, 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
